// File: rtl/sc_reg_counter_pkg.sv
// Shared constants for the mode-selectable up/down counter.
// Saturation mode codes and default geometry.
package sc_reg_counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 1;

endpackage

// File: rtl/sc_reg_counter_mode_if.sv
// Control/status bundle for the counter.
// master drives the controls, slave is the counter side.
interface sc_reg_counter_mode_if
  import sc_reg_counter_pkg::*;
#(
  parameter int W = DEF_WIDTH
);

  logic         clear_n;
  logic         load_n;
  logic         up_n;
  logic         dn_n;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         tc;
  logic         tick;

  modport master (
    output clear_n, load_n, up_n, dn_n, data,
    input  count, tc, tick
  );

  modport slave (
    input  clear_n, load_n, up_n, dn_n, data,
    output count, tc, tick
  );

endinterface

// File: rtl/sc_reg_counter_prescaler.sv
// Modulo-PRESCALE cycle counter producing the count-enable tick.
// Tick is suppressed while the counter is being cleared or loaded.
module sc_reg_counter_prescaler
  import sc_reg_counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last & ~i_clear;

  // Free-running divider, restarted by clear/load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_reg_counter_mode.sv
// Up/down counter with clear, load, prescaled stepping and
// a one-cycle terminal-count flag; wraps or saturates by parameter.
module sc_reg_counter_mode
  import sc_reg_counter_pkg::*;
#(
  parameter int RegCOUNTER_DATAWIDTH = DEF_WIDTH,
  parameter int RegCOUNTER_PRESCALE  = DEF_PRESCALE,
  parameter int RegCOUNTER_SATURATE  = MODE_WRAP
) (
  input  logic                            SC_RegCOUNTER_CLOCK_50,
  input  logic                            SC_RegCOUNTER_RESET_InLow,
  input  logic                            SC_RegCOUNTER_clear_InLow,
  input  logic                            SC_RegCOUNTER_load_InLow,
  input  logic                            SC_RegCOUNTER_upcount_InLow,
  input  logic                            SC_RegCOUNTER_downcount_InLow,
  input  logic [RegCOUNTER_DATAWIDTH-1:0] SC_RegCOUNTER_data_InBUS,
  output logic [RegCOUNTER_DATAWIDTH-1:0] SC_RegCOUNTER_data_OutBUS,
  output logic                            SC_RegCOUNTER_tc_OutHigh,
  output logic                            SC_RegCOUNTER_tick_OutHigh
);

  localparam int W = RegCOUNTER_DATAWIDTH;
  localparam logic [W-1:0] ALL1 = '1;
  localparam bit SAT = (RegCOUNTER_SATURATE == MODE_SAT);

  logic [W-1:0] r_count;
  logic         r_tc;
  logic [W-1:0] w_count_nxt;
  logic         w_tc_nxt;
  logic         w_clear;
  logic         w_load;
  logic         w_up;
  logic         w_dn;
  logic         w_tick;

  // Clear outranks load; up/down only count when exclusive.
  assign w_clear = ~SC_RegCOUNTER_clear_InLow;
  assign w_load  = ~SC_RegCOUNTER_load_InLow & SC_RegCOUNTER_clear_InLow;
  assign w_up    = w_tick & ~SC_RegCOUNTER_upcount_InLow
                 & SC_RegCOUNTER_downcount_InLow;
  assign w_dn    = w_tick & ~SC_RegCOUNTER_downcount_InLow
                 & SC_RegCOUNTER_upcount_InLow;

  sc_reg_counter_prescaler #(
    .PRESCALE (RegCOUNTER_PRESCALE)
  ) u_presc (
    .i_clk   (SC_RegCOUNTER_CLOCK_50),
    .i_rst_n (SC_RegCOUNTER_RESET_InLow),
    .i_clear (w_clear | w_load),
    .o_tick  (w_tick)
  );

  // Next count and terminal-count flag.
  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    unique case (1'b1)
      w_clear: w_count_nxt = '0;
      w_load:  w_count_nxt = SC_RegCOUNTER_data_InBUS;
      w_up: begin
        if (r_count == ALL1) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = SAT ? ALL1 : '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      w_dn: begin
        if (r_count == '0) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = SAT ? '0 : ALL1;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Count and tc state register.
  always_ff @(posedge SC_RegCOUNTER_CLOCK_50
              or negedge SC_RegCOUNTER_RESET_InLow) begin
    if (!SC_RegCOUNTER_RESET_InLow) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign SC_RegCOUNTER_data_OutBUS  = r_count;
  assign SC_RegCOUNTER_tc_OutHigh   = r_tc;
  assign SC_RegCOUNTER_tick_OutHigh = w_tick;

endmodule

// File: tb/tb_sc_reg_counter_mode.sv
// Directed scoreboard bench: wrap/P1, saturate/P1 and wrap/P3 counters.
// Expected results are queued at drive time and checked after the edge.
module tb_sc_reg_counter_mode;
  import sc_reg_counter_pkg::*;

  typedef struct {
    int         k;
    string      tag;
    logic [3:0] cnt;
    logic       tc;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sc_reg_counter_mode_if #(.W(4)) m0 ();
  sc_reg_counter_mode_if #(.W(4)) m1 ();
  sc_reg_counter_mode_if #(.W(4)) m2 ();

  sc_reg_counter_mode #(
    .RegCOUNTER_DATAWIDTH (4),
    .RegCOUNTER_PRESCALE  (1),
    .RegCOUNTER_SATURATE  (MODE_WRAP)
  ) dut0 (
    .SC_RegCOUNTER_CLOCK_50        (clk),
    .SC_RegCOUNTER_RESET_InLow     (rst_n),
    .SC_RegCOUNTER_clear_InLow     (m0.clear_n),
    .SC_RegCOUNTER_load_InLow      (m0.load_n),
    .SC_RegCOUNTER_upcount_InLow   (m0.up_n),
    .SC_RegCOUNTER_downcount_InLow (m0.dn_n),
    .SC_RegCOUNTER_data_InBUS      (m0.data),
    .SC_RegCOUNTER_data_OutBUS     (m0.count),
    .SC_RegCOUNTER_tc_OutHigh      (m0.tc),
    .SC_RegCOUNTER_tick_OutHigh    (m0.tick)
  );

  sc_reg_counter_mode #(
    .RegCOUNTER_DATAWIDTH (4),
    .RegCOUNTER_PRESCALE  (1),
    .RegCOUNTER_SATURATE  (MODE_SAT)
  ) dut1 (
    .SC_RegCOUNTER_CLOCK_50        (clk),
    .SC_RegCOUNTER_RESET_InLow     (rst_n),
    .SC_RegCOUNTER_clear_InLow     (m1.clear_n),
    .SC_RegCOUNTER_load_InLow      (m1.load_n),
    .SC_RegCOUNTER_upcount_InLow   (m1.up_n),
    .SC_RegCOUNTER_downcount_InLow (m1.dn_n),
    .SC_RegCOUNTER_data_InBUS      (m1.data),
    .SC_RegCOUNTER_data_OutBUS     (m1.count),
    .SC_RegCOUNTER_tc_OutHigh      (m1.tc),
    .SC_RegCOUNTER_tick_OutHigh    (m1.tick)
  );

  sc_reg_counter_mode #(
    .RegCOUNTER_DATAWIDTH (4),
    .RegCOUNTER_PRESCALE  (3),
    .RegCOUNTER_SATURATE  (MODE_WRAP)
  ) dut2 (
    .SC_RegCOUNTER_CLOCK_50        (clk),
    .SC_RegCOUNTER_RESET_InLow     (rst_n),
    .SC_RegCOUNTER_clear_InLow     (m2.clear_n),
    .SC_RegCOUNTER_load_InLow      (m2.load_n),
    .SC_RegCOUNTER_upcount_InLow   (m2.up_n),
    .SC_RegCOUNTER_downcount_InLow (m2.dn_n),
    .SC_RegCOUNTER_data_InBUS      (m2.data),
    .SC_RegCOUNTER_data_OutBUS     (m2.count),
    .SC_RegCOUNTER_tc_OutHigh      (m2.tc),
    .SC_RegCOUNTER_tick_OutHigh    (m2.tick)
  );

  task automatic drive(input int k, input logic c, input logic l,
                       input logic u, input logic d,
                       input logic [3:0] dat);
    case (k)
      0: begin
        m0.clear_n = c; m0.load_n = l;
        m0.up_n = u; m0.dn_n = d; m0.data = dat;
      end
      1: begin
        m1.clear_n = c; m1.load_n = l;
        m1.up_n = u; m1.dn_n = d; m1.data = dat;
      end
      default: begin
        m2.clear_n = c; m2.load_n = l;
        m2.up_n = u; m2.dn_n = d; m2.data = dat;
      end
    endcase
  endtask

  task automatic expect_out(input int k, input string tag,
                            input logic [3:0] cnt, input logic tc,
                            input logic tick);
    exp_t e;
    e.k = k; e.tag = tag; e.cnt = cnt; e.tc = tc; e.tick = tick;
    q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    logic [3:0] ac;
    logic at, ak;
    e = q.pop_front();
    case (e.k)
      0:       begin ac = m0.count; at = m0.tc; ak = m0.tick; end
      1:       begin ac = m1.count; at = m1.tc; ak = m1.tick; end
      default: begin ac = m2.count; at = m2.tc; ak = m2.tick; end
    endcase
    checks++;
    assert (ac === e.cnt) else begin
      errors++;
      $error("FAIL %s dut%0d count got %h exp %h", e.tag, e.k, ac, e.cnt);
    end
    checks++;
    assert (at === e.tc) else begin
      errors++;
      $error("FAIL %s dut%0d tc got %b exp %b", e.tag, e.k, at, e.tc);
    end
    checks++;
    assert (ak === e.tick) else begin
      errors++;
      $error("FAIL %s dut%0d tick got %b exp %b", e.tag, e.k, ak, e.tick);
    end
  endtask

  task automatic step(input int k, input string tag,
                      input logic c, input logic l,
                      input logic u, input logic d,
                      input logic [3:0] dat, input logic [3:0] ecnt,
                      input logic etc, input logic etk);
    drive(k, c, l, u, d, dat);
    expect_out(k, tag, ecnt, etc, etk);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    drive(0, 1, 1, 1, 1, 4'h0);
    drive(1, 1, 1, 1, 1, 4'h0);
    drive(2, 1, 1, 1, 1, 4'h0);
    #12;
    expect_out(0, "reset0", 4'h0, 1'b0, 1'b1); compare();
    expect_out(1, "reset1", 4'h0, 1'b0, 1'b1); compare();
    expect_out(2, "reset2", 4'h0, 1'b0, 1'b0); compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // wrap counter, prescale 1
    step(0, "ld7",    1, 0, 1, 1, 4'h7, 4'h7, 0, 0);
    #2;
    drive(0, 1, 1, 1, 1, 4'h0);
    rst_n = 1'b0;
    #1;
    expect_out(0, "rst_async", 4'h0, 1'b0, 1'b1); compare();
    #1;
    rst_n = 1'b1;
    step(0, "ldE",    1, 0, 1, 1, 4'hE, 4'hE, 0, 0);
    step(0, "upF",    1, 1, 0, 1, 4'h0, 4'hF, 0, 1);
    step(0, "upwrap", 1, 1, 0, 1, 4'h0, 4'h0, 1, 1);
    step(0, "up1",    1, 1, 0, 1, 4'h0, 4'h1, 0, 1);
    step(0, "clr",    0, 1, 1, 1, 4'h0, 4'h0, 0, 0);
    step(0, "dnwrap", 1, 1, 1, 0, 4'h0, 4'hF, 1, 1);
    step(0, "dnE",    1, 1, 1, 0, 4'h0, 4'hE, 0, 1);
    step(0, "clrld",  0, 0, 1, 1, 4'h9, 4'h0, 0, 0);
    step(0, "ld5",    1, 0, 1, 1, 4'h5, 4'h5, 0, 0);
    step(0, "updn",   1, 1, 0, 0, 4'h0, 4'h5, 0, 1);
    step(0, "idle",   1, 1, 1, 1, 4'h0, 4'h5, 0, 1);

    // saturating counter, prescale 1
    step(1, "sldE",   1, 0, 1, 1, 4'hE, 4'hE, 0, 0);
    step(1, "supF",   1, 1, 0, 1, 4'h0, 4'hF, 0, 1);
    step(1, "ssat1",  1, 1, 0, 1, 4'h0, 4'hF, 1, 1);
    step(1, "ssat2",  1, 1, 0, 1, 4'h0, 4'hF, 1, 1);
    step(1, "sdnE",   1, 1, 1, 0, 4'h0, 4'hE, 0, 1);
    step(1, "sclr",   0, 1, 1, 1, 4'h0, 4'h0, 0, 0);
    step(1, "sdn0",   1, 1, 1, 0, 4'h0, 4'h0, 1, 1);
    step(1, "sidle",  1, 1, 1, 1, 4'h0, 4'h0, 0, 1);

    // wrap counter, prescale 3
    step(2, "pclr",   0, 1, 1, 1, 4'h0, 4'h0, 0, 0);
    for (int n = 1; n <= 9; n++) begin
      step(2, "pup", 1, 1, 0, 1, 4'h0, 4'(n / 3), 0, (n % 3) == 2);
    end
    step(2, "pup10",  1, 1, 0, 1, 4'h0, 4'h3, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(2, "prst", 4'h0, 1'b0, 1'b0); compare();
    #1;
    rst_n = 1'b1;
    step(2, "pr1",    1, 1, 0, 1, 4'h0, 4'h0, 0, 0);
    step(2, "pr2",    1, 1, 0, 1, 4'h0, 4'h0, 0, 1);
    step(2, "pr3",    1, 1, 0, 1, 4'h0, 4'h1, 0, 0);
    step(2, "pldA",   1, 0, 0, 1, 4'hA, 4'hA, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_reg_counter_mode.md
SC_REG_COUNTER_MODE -- requirements
Module: sc_reg_counter_mode

Interface
REQ-001 Parameter RegCOUNTER_DATAWIDTH, default 4: counter and data bus width, legal range 2..32.
REQ-002 Parameter RegCOUNTER_PRESCALE, default 1: clock cycles per count step, legal range 1..65535.
REQ-003 Parameter RegCOUNTER_SATURATE, default 0: 0 means wrap at the limits, 1 means hold at the limits.
REQ-004 Port SC_RegCOUNTER_CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port SC_RegCOUNTER_RESET_InLow, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port SC_RegCOUNTER_clear_InLow, input, 1 bit: synchronous clear, active-low.
REQ-007 Port SC_RegCOUNTER_load_InLow, input, 1 bit: synchronous parallel load, active-low.
REQ-008 Port SC_RegCOUNTER_upcount_InLow, input, 1 bit: count-up request, active-low, level-sensitive.
REQ-009 Port SC_RegCOUNTER_downcount_InLow, input, 1 bit: count-down request, active-low, level-sensitive.
REQ-010 Port SC_RegCOUNTER_data_InBUS, input, DATAWIDTH bits: load value.
REQ-011 Port SC_RegCOUNTER_data_OutBUS, output, DATAWIDTH bits: registered count.
REQ-012 Port SC_RegCOUNTER_tc_OutHigh, output, 1 bit: terminal-count pulse, registered.
REQ-013 Port SC_RegCOUNTER_tick_OutHigh, output, 1 bit: prescaler tick, combinational from prescaler state.

Function
REQ-014 Priority per edge SHALL be: clear, then load, then count.
REQ-015 Clear low SHALL set the count to 0, the prescaler to 0 and tc to 0.
REQ-016 Load low, with clear high, SHALL set count = data_InBUS, prescaler = 0 and tc = 0.
REQ-017 The prescaler SHALL advance every cycle when neither clear nor load is active.
REQ-018 The prescaler SHALL wrap from PRESCALE-1 to 0; tick SHALL be high while the prescaler equals PRESCALE-1.
REQ-019 PRESCALE = 1 SHALL make tick constantly high except during clear or load.
REQ-020 A count step SHALL occur only on an edge where tick = 1 and exactly one of upcount or downcount is low.
REQ-021 Upcount and downcount both low, or both high, SHALL hold the count with tc = 0 (prescaler still advances).
REQ-022 Up-step: count+1; at all-ones, wrap to 0 when SATURATE=0, or hold all-ones when SATURATE=1.
REQ-023 Down-step: count-1; at 0, wrap to all-ones when SATURATE=0, or hold 0 when SATURATE=1.
REQ-024 tc SHALL be 1 for exactly the one cycle following an up-step taken at all-ones or a down-step taken at 0, in both SATURATE modes, and 0 otherwise.
REQ-025 Count arithmetic SHALL be unsigned modulo 2^DATAWIDTH; there SHALL be no X propagation from unused bits.
REQ-026 Latency: data_OutBUS SHALL reflect any clear, load or step one clock edge after the sampling edge.

Reset
REQ-027 RESET_InLow low SHALL immediately force count = 0, prescaler = 0 and tc = 0, regardless of clock.
REQ-028 Reset asserted mid-count SHALL abort the step; after deassertion the first step SHALL occur PRESCALE cycles later.
REQ-029 Reset deassertion SHALL be used synchronously by the integrator; the block adds no synchronizer.

Structure
REQ-030 Shared package sc_reg_counter_pkg SHALL hold the SATURATE mode constants (MODE_WRAP = 0, MODE_SAT = 1) and the default width and prescale constants.
REQ-031 The prescaler SHALL be a sub-module, sc_reg_counter_prescaler, parametrised by PRESCALE, with inputs clock, reset, clear and an output tick.
REQ-032 The counter next-state logic SHALL be a single combinational block feeding one state register.

Verification (WIDTH = 4, PRESCALE = 1 unless stated)
REQ-033 Reset mid-run at count 7 -> output 0 asynchronously; tc = 0.
REQ-034 Load 4'hE, then up held 3 cycles, SATURATE = 0 -> outputs F, 0, 1; tc = 1 only in the cycle with output 0.
REQ-035 Same stimulus with SATURATE = 1 -> outputs F, F, F; tc = 1 in the second and third cycles.
REQ-036 Count 0, down held 2 cycles, SATURATE = 0 -> outputs F, E; tc pulses once.
REQ-037 PRESCALE = 3, up held 9 cycles from 0 -> count 1, 2, 3 on cycles 3, 6, 9; tick observed every third cycle.
REQ-038 Clear and load both low with data 4'h9 -> count 0; up and down both low -> count held.
